next_pc_predictor: RTL and testbench
====================================

// Module: next_pc_predictor
// PURPOSE
//  Next-PC generation stage feeding the 32-bit PC register; output o_next_pc drives that register's D input.
//  Direct-mapped BTB with a 2-bit saturating counter per entry predicts taken branches/jumps at fetch.
//  Resolved branch outcomes from EX train the table.
//  A wrong prediction raises o_mispredict and steers o_next_pc to the corrected PC.
// PARAMETERS
//  XLEN        32  data/address width
//  IDX_W       4   BTB index bits; entries = 2**IDX_W (16)
//  TAG_W       XLEN-IDX_W-2 (26)  tag bits stored per entry
// PORTS
//  i_clk              in   1     clock, all state updates on posedge
//  i_clr              in   1     synchronous, active-high reset
//  i_stall            in   1     fetch stall; PC register holds. Lookup still combinational; no effect on training
//  i_pc               in   XLEN  current PC (PC register Q)
//  o_next_pc          out  XLEN  next PC to PC register D
//  o_pred_taken       out  1     fetch-time prediction for i_pc, carried down pipe
//  o_pred_target      out  XLEN  predicted target for i_pc, carried down pipe
//  i_ex_valid         in   1     EX holds a resolved control-flow instr this cycle
//  i_ex_pc            in   XLEN  PC of that instr
//  i_ex_taken         in   1     actual outcome
//  i_ex_target        in   XLEN  actual target
//  i_ex_pred_taken    in   1     prediction made at fetch for it
//  i_ex_pred_target   in   XLEN  target predicted at fetch
//  o_mispredict       out  1     flush IF/ID, ID/EX this cycle
// BEHAVIOUR
//  Lookup (comb, 0 latency): idx=i_pc[IDX_W+1:2], tag=i_pc[XLEN-1:IDX_W+2];
//   hit = valid[idx] && tag_q[idx]==tag; o_pred_taken = hit && ctr[idx][1]; o_pred_target = tgt[idx].
//  o_mispredict = i_ex_valid && (i_ex_taken!=i_ex_pred_taken || (i_ex_taken && i_ex_target!=i_ex_pred_target)).
//  o_next_pc priority: o_mispredict ? (i_ex_taken ? i_ex_target : i_ex_pc+4)
//   : o_pred_taken ? o_pred_target : i_pc+4. Adds wrap mod 2**XLEN.
//  Training at posedge when i_ex_valid && !i_clr, idx/tag from i_ex_pc:
//   hit: ctr sat-inc if taken, sat-dec if not (00..11 saturate); tgt<=i_ex_target if taken.
//   miss & taken: allocate valid=1, tag, tgt=i_ex_target, ctr=10 (weak taken).
//   miss & not taken: no change.
//  Same-cycle lookup and train on same idx: lookup sees pre-update state; new state visible next cycle.
//  i_stall does not block training or mispredict (EX presents each instr exactly one cycle).
//  i_clr: all valid<=0, all ctr<=01, tags/targets don't-care; overrides simultaneous training.
//  Reset state outputs (i_ex_valid=0): o_pred_taken=0, o_mispredict=0, o_next_pc=i_pc+4.
//  Misaligned targets passed through unchanged; no exception handling here.
// CONFIGURATION
//  PRED_STATS_EN defined: adds outputs o_stat_branches, o_stat_mispred (32 bit each);
//   +1 per cycle with i_ex_valid / o_mispredict, saturate at 32'hFFFF_FFFF, cleared by i_clr.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package pred_pkg: XLEN, IDX_W, TAG_W, ctr_t (2-bit) with ST_NT=00, WK_NT=01, WK_T=10, ST_T=11,
//   btb_entry_t {valid, tag, tgt, ctr}.
//  Sub-module sat_counter2: 2-bit saturating next-state (inputs ctr, taken; out ctr_next).
//  Top: entry array, lookup mux, mispredict compare, next-PC mux, optional stats.
// TESTING
//  1 After i_clr, i_pc=0x100 -> o_next_pc=0x104, o_pred_taken=0, o_mispredict=0.
//  2 EX 0x100 taken tgt 0x200 pred 0 -> o_mispredict=1, o_next_pc=0x200; next cycle i_pc=0x100 -> pred 1, next 0x200.
//  3 Train 0x100 not-taken twice (pred 1 first) -> ctr 10->01->00; lookup 0x100 -> next 0x104; 3 taken -> 11 saturate.
//  4 Alias: 0x100 allocated, then 0x140 (same idx, diff tag) taken -> replaces; lookup 0x100 misses -> 0x104.
//  5 Same cycle i_pc=0x100 and EX allocates 0x100 -> o_pred_taken=0 that cycle, 1 next cycle; i_stall=1 still trains.
//  6 i_clr with i_ex_valid=1 -> no allocation; PRED_STATS_EN: 3 branches/1 mispredict -> stats 3/1, clr -> 0/0.

Source files
------------

// File: rtl/next_pc_predictor_pkg.sv
// Shared types and sizes for the next-PC predictor: BTB geometry, counter encoding, entry layout.
// Latency: n/a (types only).
// Backpressure: n/a.
package pred_pkg;

  localparam int XLEN    = 32;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = XLEN - IDX_W - 2;
  localparam int ENTRIES = 1 << IDX_W;

  // 2-bit direction counter; the MSB is the taken prediction
  typedef enum logic [1:0] {
    ST_NT = 2'b00,
    WK_NT = 2'b01,
    WK_T  = 2'b10,
    ST_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  tgt;
    ctr_t             ctr;
  } btb_entry_t;

  // Sequential fall-through address; wraps modulo 2**XLEN
  function automatic logic [XLEN-1:0] pc_inc4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// Fetch/EX-side bundle of the next-PC predictor; the core drives it as master, the predictor is slave.
// Latency: n/a (wiring only); o_* fields are combinational from the predictor.
// Backpressure: none; PRED_STATS_EN adds the statistics counter fields.
interface next_pc_predictor_if;

  logic                      i_stall;
  logic [pred_pkg::XLEN-1:0] i_pc;
  logic [pred_pkg::XLEN-1:0] o_next_pc;
  logic                      o_pred_taken;
  logic [pred_pkg::XLEN-1:0] o_pred_target;
  logic                      i_ex_valid;
  logic [pred_pkg::XLEN-1:0] i_ex_pc;
  logic                      i_ex_taken;
  logic [pred_pkg::XLEN-1:0] i_ex_target;
  logic                      i_ex_pred_taken;
  logic [pred_pkg::XLEN-1:0] i_ex_pred_target;
  logic                      o_mispredict;
`ifdef PRED_STATS_EN
  logic [31:0]               o_stat_branches;
  logic [31:0]               o_stat_mispred;
`endif

`ifdef PRED_STATS_EN
  modport master (
    output i_stall, i_pc, i_ex_valid, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    input  o_next_pc, o_pred_taken, o_pred_target, o_mispredict,
           o_stat_branches, o_stat_mispred
  );
  modport slave (
    input  i_stall, i_pc, i_ex_valid, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    output o_next_pc, o_pred_taken, o_pred_target, o_mispredict,
           o_stat_branches, o_stat_mispred
  );
`else
  modport master (
    output i_stall, i_pc, i_ex_valid, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    input  o_next_pc, o_pred_taken, o_pred_target, o_mispredict
  );
  modport slave (
    input  i_stall, i_pc, i_ex_valid, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    output o_next_pc, o_pred_taken, o_pred_target, o_mispredict
  );
`endif

endinterface

// File: rtl/next_pc_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: step toward strongly-taken or strongly-not-taken.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module sat_counter2
  import pred_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // Saturating step; the end states hold rather than wrap
  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      ST_NT: ctr_next = taken ? WK_NT : ST_NT;
      WK_NT: ctr_next = taken ? WK_T  : ST_NT;
      WK_T:  ctr_next = taken ? ST_T  : WK_NT;
      ST_T:  ctr_next = taken ? ST_T  : WK_T;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC generation: direct-mapped BTB + 2-bit counters predict at fetch, EX outcomes train and redirect.
// Latency: lookup, mispredict and next-PC are combinational (0 cycles); training lands on the next posedge.
// Backpressure: none; i_stall only holds the external PC register, lookup and training ignore it.
// Optional: define PRED_STATS_EN for saturating branch / mispredict counters.
module next_pc_predictor
  import pred_pkg::*;
(
  input logic                 i_clk,
  input logic                 i_clr,
  next_pc_predictor_if.slave  bus
);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  btb_entry_t       pc_ent;
  btb_entry_t       ex_ent;
  logic             pc_hit;
  logic             ex_hit;
  logic             mispredict;
  ctr_t             ex_ctr_next;
  logic             stall_unused;

  // The stall only freezes the PC register outside this block
  assign stall_unused = bus.i_stall;

  assign pc_idx = bus.i_pc[IDX_W+1:2];
  assign pc_tag = bus.i_pc[XLEN-1:IDX_W+2];
  assign ex_idx = bus.i_ex_pc[IDX_W+1:2];
  assign ex_tag = bus.i_ex_pc[XLEN-1:IDX_W+2];

  // Fetch lookup and EX mispredict check, both from pre-update table state
  always_comb begin
    pc_ent     = btb_q[pc_idx];
    ex_ent     = btb_q[ex_idx];
    pc_hit     = pc_ent.valid && (pc_ent.tag == pc_tag);
    ex_hit     = ex_ent.valid && (ex_ent.tag == ex_tag);
    mispredict = bus.i_ex_valid &&
                 ((bus.i_ex_taken != bus.i_ex_pred_taken) ||
                  (bus.i_ex_taken && (bus.i_ex_target != bus.i_ex_pred_target)));
  end

  sat_counter2 u_ctr (
    .ctr      (ex_ent.ctr),
    .taken    (bus.i_ex_taken),
    .ctr_next (ex_ctr_next)
  );

  // Next-PC select: redirect from EX beats fetch prediction beats fall-through
  always_comb begin
    bus.o_pred_taken  = pc_hit && pc_ent.ctr[1];
    bus.o_pred_target = pc_ent.tgt;
    bus.o_mispredict  = mispredict;
    if (mispredict)
      bus.o_next_pc = bus.i_ex_taken ? bus.i_ex_target : pc_inc4(bus.i_ex_pc);
    else if (bus.o_pred_taken)
      bus.o_next_pc = pc_ent.tgt;
    else
      bus.o_next_pc = pc_inc4(bus.i_pc);
  end

  // Table training; clear wins over a simultaneous EX update, tags/targets left as-is
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
        btb_q[i].ctr   <= WK_NT;
      end
    end else if (bus.i_ex_valid) begin
      if (ex_hit) begin
        btb_q[ex_idx].ctr <= ex_ctr_next;
        if (bus.i_ex_taken)
          btb_q[ex_idx].tgt <= bus.i_ex_target;
      end else if (bus.i_ex_taken) begin
        btb_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, tgt: bus.i_ex_target, ctr: WK_T};
      end
    end
  end

`ifdef PRED_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Resolved-branch and mispredict counters, saturating at all-ones
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (bus.i_ex_valid && (stat_br_q != 32'hFFFF_FFFF))
        stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != 32'hFFFF_FFFF))
        stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign bus.o_stat_branches = stat_br_q;
  assign bus.o_stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed-vector bench for next_pc_predictor with a queue-based scoreboard.
// Latency: expectations are combinational outputs sampled on the falling edge of the vector's cycle.
// Backpressure: none.
module tb_next_pc_predictor;

  logic clk;
  logic clr;

  next_pc_predictor_if bus ();

  next_pc_predictor dut (
    .i_clk (clk),
    .i_clr (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] next_pc;
    logic        pred;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  logic mon_vld;
  int   n_cmp;
  int   n_bad;
  int   vec_id;

  // Apply one cycle of stimulus just after the rising edge and queue its expectation
  task automatic vec(input logic c, input logic stall, input logic [31:0] pc,
                     input logic exv, input logic [31:0] expc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic chk, input logic [31:0] e_next, input logic e_pred,
                     input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    clr                  = c;
    bus.i_stall          = stall;
    bus.i_pc             = pc;
    bus.i_ex_valid       = exv;
    bus.i_ex_pc          = expc;
    bus.i_ex_taken       = tk;
    bus.i_ex_target      = tgt;
    bus.i_ex_pred_taken  = ptk;
    bus.i_ex_pred_target = ptgt;
    vec_id++;
    if (chk) begin
      e.id = vec_id; e.next_pc = e_next; e.pred = e_pred; e.mis = e_mis;
      exp_q.push_back(e);
    end
    mon_vld = chk;
  endtask

  task automatic idle(input logic [31:0] pc, input logic [31:0] e_next, input logic e_pred);
    vec(1'b0, 1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, e_next, e_pred, 1'b0);
  endtask

  task automatic ex(input logic [31:0] pc, input logic [31:0] expc, input logic tk,
                    input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                    input logic [31:0] e_next, input logic e_pred, input logic e_mis);
    vec(1'b0, 1'b0, pc, 1'b1, expc, tk, tgt, ptk, ptgt, 1'b1, e_next, e_pred, e_mis);
  endtask

  // Monitor: pop and compare whenever the driver marks the cycle as observed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_vld) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_underflow: output observed with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          if (bus.o_next_pc !== e.next_pc || bus.o_pred_taken !== e.pred ||
              bus.o_mispredict !== e.mis) begin
            n_bad++;
            $display("FAIL vec%0d: got next_pc=%h pred=%b mis=%b, expected next_pc=%h pred=%b mis=%b",
                     e.id, bus.o_next_pc, bus.o_pred_taken, bus.o_mispredict,
                     e.next_pc, e.pred, e.mis);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; vec_id = 0; mon_vld = 1'b0;
    clr = 1'b1;
    bus.i_stall = 1'b0; bus.i_pc = 32'h100; bus.i_ex_valid = 1'b0; bus.i_ex_pc = '0;
    bus.i_ex_taken = 1'b0; bus.i_ex_target = '0; bus.i_ex_pred_taken = 1'b0;
    bus.i_ex_pred_target = '0;

    // Reset
    vec(1'b1, 1'b0, 32'h100, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    vec(1'b1, 1'b0, 32'h100, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle(32'h100, 32'h104, 1'b0);

    // Allocate 0x100 -> 0x200; same-cycle lookup still sees the empty entry
    ex(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 32'h200, 1'b0, 1'b1);
    idle(32'h100, 32'h200, 1'b1);

    // Two not-taken: 10 -> 01 -> 00; 0x300 shares index 0 but misses on tag
    ex(32'h300, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 32'h104, 1'b0, 1'b1);
    ex(32'h300, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0,   32'h304, 1'b0, 1'b0);
    idle(32'h100, 32'h104, 1'b0);

    // Four taken: 00 -> 01 -> 10 -> 11 -> 11 (saturate)
    ex(32'h300, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   32'h200, 1'b0, 1'b1);
    ex(32'h300, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0,   32'h200, 1'b0, 1'b1);
    ex(32'h300, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 32'h304, 1'b0, 1'b0);
    ex(32'h300, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 32'h304, 1'b0, 1'b0);
    // One not-taken: 11 -> 10 still predicts taken
    ex(32'h300, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200, 32'h104, 1'b0, 1'b1);
    idle(32'h100, 32'h200, 1'b1);
    // Direction right, target wrong
    ex(32'h300, 32'h100, 1'b1, 32'h200, 1'b1, 32'h204, 32'h200, 1'b0, 1'b1);

    // Alias: 0x140 evicts 0x100 at index 0
    ex(32'h300, 32'h140, 1'b1, 32'h400, 1'b0, 32'h0, 32'h400, 1'b0, 1'b1);
    idle(32'h100, 32'h104, 1'b0);
    idle(32'h140, 32'h400, 1'b1);
    // Miss and not-taken leaves the table alone
    ex(32'h140, 32'h180, 1'b0, 32'h0, 1'b0, 32'h0, 32'h400, 1'b1, 1'b0);
    idle(32'h180, 32'h184, 1'b0);

    // Stall does not block training or the redirect
    vec(1'b0, 1'b1, 32'h204, 1'b1, 32'h204, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b1);
    vec(1'b0, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h500, 1'b1, 1'b0);

    // Clear beats a simultaneous allocation and invalidates everything
    vec(1'b1, 1'b0, 32'h208, 1'b1, 32'h208, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    idle(32'h208, 32'h20C, 1'b0);
    idle(32'h204, 32'h208, 1'b0);
    idle(32'h140, 32'h144, 1'b0);

    // Address wrap on both fall-through paths
    idle(32'hFFFF_FFFC, 32'h0, 1'b0);
    ex(32'h100, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h800, 32'h0, 1'b0, 1'b1);

`ifdef PRED_STATS_EN
    // Three branches, one mispredict, counted from a fresh clear
    vec(1'b1, 1'b0, 32'h300, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    ex(32'h300, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0, 32'h304, 1'b0, 1'b0);
    ex(32'h300, 32'h104, 1'b1, 32'h700, 1'b0, 32'h0, 32'h700, 1'b0, 1'b1);
    ex(32'h300, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0, 32'h304, 1'b0, 1'b0);
    vec(1'b0, 1'b0, 32'h300, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.o_stat_branches !== 32'd3 || bus.o_stat_mispred !== 32'd1) begin
      n_bad++;
      $display("FAIL stats_count: got %0d/%0d, expected 3/1", bus.o_stat_branches, bus.o_stat_mispred);
    end
    vec(1'b1, 1'b0, 32'h300, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    vec(1'b0, 1'b0, 32'h300, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.o_stat_branches !== 32'd0 || bus.o_stat_mispred !== 32'd0) begin
      n_bad++;
      $display("FAIL stats_clear: got %0d/%0d, expected 0/0", bus.o_stat_branches, bus.o_stat_mispred);
    end
`endif

    // Drain: every queued expectation must have been consumed
    vec(1'b0, 1'b0, 32'h100, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
